fifo_stream_drain: RTL and testbench



---
 rtl/stream_pkg.sv | 6 +
 rtl/fifo_out_buf.sv | 28 ++
 rtl/fifo_stream_drain.sv | 79 +++++++
 tb/tb_fifo_stream_drain.sv | 136 +++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// stream_pkg: occupancy encoding and default widths for fifo_stream_drain.
package stream_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;
endpackage

// File: rtl/fifo_out_buf.sv
// fifo_out_buf: 2-entry head/tail register pair; shift moves tail into head.
import stream_pkg::*;
module fifo_out_buf #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_head_i,
  input  logic             load_tail_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o
);
  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  always_comb begin
    head_d = shift_i ? tail_q : load_head_i ? din_i : head_q;
    tail_d = load_tail_i ? din_i : tail_q;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  assign head_o = head_q;
endmodule

// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: pops a FIFO and re-presents words on a registered valid/ready stream.
// Define STREAM_STATS_EN to add the delivered-word counter m_count_o.
import stream_pkg::*;
module fifo_stream_drain #(
  parameter int WIDTH = WIDTH_DEF
`ifdef STREAM_STATS_EN
  , parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             fifo_empty_i,
  output logic             fifo_pop_o,
  input  logic [WIDTH-1:0] fifo_data_i,
  input  logic             flush_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o
`ifdef STREAM_STATS_EN
  , output logic [CNT_W-1:0] m_count_o
`endif
);
  occ_e state_q, state_d;
  logic valid_q, valid_d, pop, take, load_head, load_tail, shift;
  assign pop = !fifo_empty_i && state_q != TWO && !flush_i && !reset_i;
  assign take = valid_q && m_ready_i;
  assign fifo_pop_o = pop;
  assign m_valid_o = valid_q;
  always_comb begin
    state_d = state_q;
    load_head = 1'b0;
    load_tail = 1'b0;
    shift = 1'b0;
    if (flush_i) state_d = EMPTY;
    else case (state_q)
      EMPTY: if (pop) begin
        state_d = ONE;
        load_head = 1'b1;
      end
      ONE: begin
        state_d = (pop && !take) ? TWO : (take && !pop) ? EMPTY : ONE;
        load_head = pop && take;
        load_tail = pop && !take;
      end
      TWO: if (take) begin
        state_d = ONE;
        shift = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    valid_d = state_d != EMPTY;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  fifo_out_buf #(.WIDTH(WIDTH)) u_buf (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_head_i(load_head),
    .load_tail_i(load_tail),
    .shift_i    (shift),
    .din_i      (fifo_data_i),
    .head_o     (m_data_o)
  );
`ifdef STREAM_STATS_EN
  // Counts takes even in a flush cycle; only reset clears it.
  logic [CNT_W-1:0] count_q, count_d;
  always_comb count_d = take ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) count_q <= '0;
    else count_q <= count_d;
  assign m_count_o = count_q;
`endif
endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb_fifo_stream_drain: directed checks of fifo_stream_drain against a small FIFO model.
module tb_fifo_stream_drain;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, ready = 1'b0;
  logic fifo_empty, fifo_pop, m_valid;
  logic [7:0] fifo_data, m_data;
  logic [7:0] mem [16];
  logic [4:0] rd = '0, wr = '0;
  int tests = 0, fails = 0;
`ifdef STREAM_STATS_EN
  logic [3:0] m_count;
`endif
  always #5 clk = ~clk;
  assign fifo_empty = rd == wr;
  assign fifo_data = mem[rd[3:0]];
  always @(posedge clk) if (fifo_pop) rd <= rd + 5'd1;
  fifo_stream_drain #(
    .WIDTH(8)
`ifdef STREAM_STATS_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .fifo_empty_i(fifo_empty),
    .fifo_pop_o  (fifo_pop),
    .fifo_data_i (fifo_data),
    .flush_i     (flush),
    .m_valid_o   (m_valid),
    .m_ready_i   (ready),
    .m_data_o    (m_data)
`ifdef STREAM_STATS_EN
    , .m_count_o (m_count)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic push(input logic [7:0] d);
    mem[wr[3:0]] = d;
    wr = wr + 5'd1;
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    @(negedge clk);
    chk("rst_pop", fifo_pop, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    rst = 1'b0;
    #1 chk("t1_pop0", fifo_pop, 1);
    @(negedge clk);
    chk("t1_d0", {m_valid, m_data}, 9'h111);
    step(); chk("t1_d1", {m_valid, m_data}, 9'h122);
    step(); chk("t1_d2", {m_valid, m_data}, 9'h133);
    chk("t1_nopop", fifo_pop, 0);
`ifdef STREAM_STATS_EN
    chk("t1_cnt", m_count, 2);
`endif
    step(); chk("t1_idle", m_valid, 0);
`ifdef STREAM_STATS_EN
    chk("t1_cnt3", m_count, 3);
`endif
    ready = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #1 chk("bp_pop1", fifo_pop, 1);
    step(); chk("bp_pop2", fifo_pop, 1);
    step(); chk("bp_pop_stop", fifo_pop, 0);
    chk("bp_head", {m_valid, m_data}, 9'h111);
    step(); chk("bp_hold", {m_valid, m_data}, 9'h111);
    chk("bp_pop_stop2", fifo_pop, 0);
    ready = 1'b1;
    step(); chk("bp_w2", {m_valid, m_data}, 9'h122);
    step(); chk("bp_w3", {m_valid, m_data}, 9'h133);
    step(); chk("bp_w4", {m_valid, m_data}, 9'h144);
    step(); chk("bp_done", m_valid, 0);
    for (int i = 0; i < 6; i++) begin
      ready = i[0];
      #1 chk("emp_pop", fifo_pop, 0);
      step(); chk("emp_valid", m_valid, 0);
    end
    ready = 1'b0;
    push(8'hA5); push(8'h5A);
    step(); step();
    chk("fl_two", {m_valid, m_data, fifo_pop}, 10'h34A);
    push(8'h77);
    flush = 1'b1;
    #1 chk("fl_nopop", fifo_pop, 0);
    step(); flush = 1'b0;
    chk("fl_valid", {m_valid, m_data}, 9'h0A5);
    #1 chk("fl_pop_after", fifo_pop, 1);
    step(); chk("fl_next", {m_valid, m_data}, 9'h177);
    push(8'h88);
    #1 chk("fl1_pop_pre", fifo_pop, 1);
    flush = 1'b1;
    #1 chk("fl1_nopop", fifo_pop, 0);
    step(); flush = 1'b0;
    chk("fl1_valid", m_valid, 0);
    step(); chk("fl1_next", {m_valid, m_data}, 9'h188);
    ready = 1'b1;
    step(); ready = 1'b0;
    chk("fl1_drain", m_valid, 0);
    push(8'h91); push(8'h92); push(8'h93);
    step(); step();
    chk("rs_pre", {m_valid, m_data}, 9'h191);
    #1 rst = 1'b1;
    #1 chk("rs_async", {m_valid, m_data, fifo_pop}, 10'h000);
    #1 rst = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    chk("rs_first", {m_valid, m_data}, 9'h193);
    step(); chk("rs_drain", m_valid, 0);
`ifdef STREAM_STATS_EN
    chk("rs_cnt", m_count, 1);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 9; i++) push(8'(i));
      for (int i = 0; i < 11; i++) step();
    end
    chk("cnt_wrap", m_count, 3);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
